// File: rtl/aes_fpga_pkg.sv
// Shared constants, ASCII helpers and UART state encoding for the AES FPGA top.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_fpga_pkg;

    localparam int FRAME_LEN = 36;

    localparam logic [7:0] CHAR_E     = 8'h45;
    localparam logic [7:0] CHAR_D     = 8'h44;
    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Lowercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'a'-'f'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; tx is a flop, LSB first, CLKS_PER_BIT cycles per bit.
// Latency: accepted byte drives the start bit in the next cycle; 10*CLKS_PER_BIT cycles per byte.
// Backpressure: byte_ready is high in IDLE and on the last STOP cycle, so back-to-back bytes have no gap.
module uart_tx_byte
    import aes_fpga_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_e      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             baud_last;
    logic             accept;

    assign baud_last  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign byte_ready = (state == IDLE) || ((state == STOP) && baud_last);
    assign accept     = byte_valid && byte_ready;

    // Bit-level sequencer: start, 8 data bits, stop; chains straight into the next start when fed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (accept) begin
                state    <= START;
                tx       <= 1'b0;
                shreg    <= byte_data;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tx       <= 1'b1;
                        baud_cnt <= '0;
                    end
                    START: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            state    <= DATA;
                            tx       <= shreg[0];
                            bit_cnt  <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {1'b0, shreg[7:1]};
                                tx      <= shreg[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/aes_result_uart_tx.sv
// Sends a latched 128-bit AES result as "E:<32 hex>\r\n" / "D:..." over 8N1 UART.
// Latency: start bit of char 0 in the cycle after send; done 360*CLKS_PER_BIT+1 cycles after send.
// Backpressure: none; send while busy is discarded and flagged by a one-cycle dropped pulse.
module aes_result_uart_tx
    import aes_fpga_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         send,
    input  logic [127:0] data_in,
    input  logic         enc_mode,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic         dropped
);

    logic [127:0] data_q;
    logic [5:0]   char_idx;
    logic [5:0]   next_idx;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_ready;

    assign next_idx = char_idx + 6'd1;

    // Character selection: char 0 comes straight from the inputs on accept, later ones from the hold register.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        if (!busy) begin
            byte_valid = send;
            byte_data  = enc_mode ? CHAR_E : CHAR_D;
        end else begin
            byte_valid = (char_idx != 6'(FRAME_LEN - 1));
            case (next_idx)
                6'd1:                byte_data = CHAR_COLON;
                6'(FRAME_LEN - 2):   byte_data = CHAR_CR;
                6'(FRAME_LEN - 1):   byte_data = CHAR_LF;
                default:             byte_data = nibble_to_ascii(data_q[127:124]);
            endcase
        end
    end

    // Frame sequencing: latch on accept, advance per serializer handshake, flag done/dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            dropped  <= 1'b0;
            char_idx <= '0;
            data_q   <= '0;
        end else begin
            done    <= 1'b0;
            dropped <= send && busy;
            if (!busy) begin
                if (send) begin
                    busy     <= 1'b1;
                    char_idx <= '0;
                    data_q   <= data_in;
                end
            end else if (byte_ready) begin
                if (char_idx == 6'(FRAME_LEN - 1)) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    char_idx <= '0;
                end else begin
                    char_idx <= next_idx;
                    if ((next_idx >= 6'd2) && (next_idx <= 6'd33)) begin
                        data_q <= {data_q[123:0], 4'h0};
                    end
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (tx)
    );

endmodule

// File: tb/tb_aes_result_uart_tx.sv
// Scoreboard bench: expected characters are derived from a formatted string of each request;
// a UART receiver process decodes tx and checks each byte against the queue.
// Control-signal timing (busy, done, dropped, reset) is checked by the stimulus process.
module tb_aes_result_uart_tx;

    localparam int CPB      = 4;
    localparam int FRAME_CY = 360 * CPB + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         send = 1'b0;
    logic [127:0] data_in = '0;
    logic         enc_mode = 1'b0;
    logic         tx;
    logic         busy;
    logic         done;
    logic         dropped;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    aes_result_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .send     (send),
        .data_in  (data_in),
        .enc_mode (enc_mode),
        .tx       (tx),
        .busy     (busy),
        .done     (done),
        .dropped  (dropped)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: the line is just the formatted text of the request.
    task automatic push_expected(input logic [127:0] d, input logic m);
        string s;
        s = $sformatf("%s:%h\r\n", m ? "E" : "D", d);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
        end
    endtask

    // Called just after a negedge: request is sampled on the following posedge.
    task automatic issue(input logic [127:0] d, input logic m);
        data_in  = d;
        enc_mode = m;
        send     = 1'b1;
        push_expected(d, m);
        @(posedge clk);
        #1 send = 1'b0;
        @(negedge clk);
        chk("start_busy_tx", {busy, tx}, 2'b10);
        chk("start_no_done", {done, dropped}, 2'b00);
    endtask

    // Entered at the negedge of the first frame cycle; returns at the negedge of the done cycle.
    task automatic wait_done();
        int  n;
        bit  busy_gap;
        n        = 1;
        busy_gap = 1'b0;
        while (!done && n < FRAME_CY + 50) begin
            @(negedge clk);
            n++;
            if (!done && !busy) busy_gap = 1'b1;
        end
        chk("done_latency", n, FRAME_CY);
        chk("busy_held", busy_gap, 1'b0);
        chk("done_state", {busy, tx}, 2'b01);
        chk("frame_len_left", exp_q.size(), 0);
    endtask

    // UART receiver / scoreboard monitor.
    initial begin
        logic [39:0] s;
        logic [7:0]  got;
        logic [7:0]  exp;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                s       = '0;
                aborted = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = tx;
                end
                if (!aborted) begin
                    for (int j = 0; j < 8; j++) got[j] = s[5 + 4*j];
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", got, 8'hxx);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("byte", got, exp);
                        chk("framing", {s[39:36], s[3:0]}, 8'hf0);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", {tx, busy, done, dropped}, 4'b1000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {tx, busy, done, dropped}, 4'b1000);

        // Encrypt NIST vector.
        @(negedge clk);
        issue(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
        wait_done();

        // Decrypt prefix with all-zero data.
        @(negedge clk);
        issue(128'h0, 1'b0);
        wait_done();

        // Collision and input isolation mid-frame.
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(d, 1'b1);
        fork
            wait_done();
            begin
                repeat (98) @(negedge clk);
                data_in  = ~d;
                enc_mode = 1'b0;
                send     = 1'b1;
                @(posedge clk);
                #1 send = 1'b0;
                @(negedge clk);
                chk("dropped_pulse", dropped, 1'b1);
                @(negedge clk);
                chk("dropped_width", dropped, 1'b0);
                repeat (300) @(negedge clk);
                data_in = {$urandom, $urandom, $urandom, $urandom};
            end
        join

        // Back-to-back: send in the done cycle.
        issue({$urandom, $urandom, $urandom, $urandom}, 1'($urandom % 2));
        wait_done();

        // Randomized frames.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            issue({$urandom, $urandom, $urandom, $urandom}, 1'($urandom % 2));
            wait_done();
        end

        // Reset in the middle of char 10.
        @(negedge clk);
        issue({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        repeat (410) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_immediate", {tx, busy}, 2'b10);
        repeat (3) begin
            @(negedge clk);
            chk("midreset_held", {tx, busy, done, dropped}, 4'b1000);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_midreset_idle", {tx, busy}, 2'b10);
        issue({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_done();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
